// File: rtl/fp_mult_pkg.sv
// Shared status bit indices, rounding-mode type and illegal-status check
// for the floating-point multiplier arbiter.
package fp_mult_pkg;

    localparam int ZERO    = 0;
    localparam int INF     = 1;
    localparam int NAN     = 2;
    localparam int TINY    = 3;
    localparam int HUGE    = 4;
    localparam int INEXACT = 5;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } rnd_t;

    // A zero or tiny result can never also be inf, nan or huge.
    function automatic logic status_illegal(input logic [4:0] s);
        logic big;
        big = s[INF] | s[NAN] | s[HUGE];
        return (s[ZERO] | s[TINY]) & big;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant logic: combinational one-hot grant, search starts at
// the pointer, pointer moves past the winner.
module rr_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         valid,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0] ptr;
    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IW'((int'(ptr) + k) % N_REQ);
            if (rst_n && !found && valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/fp_mult_arbiter.sv
// Shares one fixed-latency FP multiplier among N_REQ requesters and routes
// results back by tag. Define FP_MULT_ARB_STICKY_EN for per-requester sticky status.
module fp_mult_arbiter #(
    parameter int N_REQ = 2,
    parameter int LAT   = 3,
    parameter int DW    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*DW-1:0] req_a,
    input  logic [N_REQ*DW-1:0] req_b,
    input  logic [N_REQ*3-1:0] req_rnd,
    output logic               mul_valid,
    output logic [DW-1:0]      mul_a,
    output logic [DW-1:0]      mul_b,
    output logic [2:0]         mul_rnd,
    input  logic [DW-1:0]      mul_z,
    input  logic [7:0]         mul_status,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [DW-1:0]      rsp_z,
    output logic [7:0]         rsp_status,
    output logic               status_err,
    output logic               busy
`ifdef FP_MULT_ARB_STICKY_EN
    ,
    input  logic [N_REQ-1:0]   sticky_clr,
    output logic [N_REQ*8-1:0] sticky_status
`endif
);

    import fp_mult_pkg::*;

    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    gidx;
    rnd_t             rnd_sel;
    logic [LAT-1:0]   tag_v;
    logic [IW-1:0]    tag_i [LAT];

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (req_valid),
        .grant (grant),
        .idx   (gidx)
    );

    assign req_ready = grant;
    assign mul_valid = |grant;
    assign mul_rnd   = rnd_sel;

    always_comb begin
        mul_a   = '0;
        mul_b   = '0;
        rnd_sel = RNE;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                mul_a   = req_a[i*DW +: DW];
                mul_b   = req_b[i*DW +: DW];
                rnd_sel = rnd_t'(req_rnd[i*3 +: 3]);
            end
        end
    end

    // Tag pipeline mirrors the multiplier so each result finds its owner.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_v      <= '0;
            for (int k = 0; k < LAT; k++) tag_i[k] <= '0;
            rsp_valid  <= '0;
            rsp_z      <= '0;
            rsp_status <= '0;
            status_err <= 1'b0;
        end else begin
            tag_v[0] <= mul_valid;
            tag_i[0] <= gidx;
            for (int k = 1; k < LAT; k++) begin
                tag_v[k] <= tag_v[k-1];
                tag_i[k] <= tag_i[k-1];
            end
            rsp_valid <= tag_v[LAT-1] ? (N_REQ'(1) << tag_i[LAT-1]) : '0;
            if (tag_v[LAT-1]) begin
                rsp_z      <= mul_z;
                rsp_status <= mul_status;
                if (status_illegal(mul_status[4:0])) status_err <= 1'b1;
            end
        end
    end

    assign busy = (|tag_v) | (|rsp_valid);

`ifdef FP_MULT_ARB_STICKY_EN
    // A clear and a new response in the same cycle keep the new bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_status <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                sticky_status[i*8 +: 8] <=
                    (sticky_clr[i] ? 8'h00 : sticky_status[i*8 +: 8]) |
                    (rsp_valid[i] ? rsp_status : 8'h00);
            end
        end
    end
`endif

endmodule
